// File: rtl/eda_compare_pkg.sv
// Shared types and helpers for the regional-max window comparator.
// Contents: FSM state enum, centre/neighbour index mapping, lowest-set-bit
// priority encoder sized for the largest supported window (7x7 -> 48 neighbours).
package eda_compare_pkg;

   localparam int unsigned PRIO_W     = 48;
   localparam int unsigned PRIO_IDX_W = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      RESULT = 2'd2,
      EMIT   = 2'd3
   } state_e;

   // Centre pixel position of a row-major window; usable in localparams.
   function automatic int unsigned centre_idx(input int unsigned window_size);
      return (window_size - 1) / 2;
   endfunction

   // Window position -> neighbour index (centre is skipped).
   function automatic int unsigned neigh_idx(input int unsigned p, input int unsigned c);
      return (p < c) ? p : p - 1;
   endfunction

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [PRIO_IDX_W-1:0] lowest_set(input logic [PRIO_W-1:0] v);
      logic [PRIO_IDX_W-1:0] r;
      r = '0;
      for (int i = PRIO_W - 1; i >= 0; i--) begin
         if (v[i]) r = PRIO_IDX_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/eda_max_tree.sv
// Combinational unsigned max reduction over N pixels.
// Ports: values  - N packed pixels, pixel i at [i*PIXEL_WIDTH +: PIXEL_WIDTH]
//        max_value - largest of the N inputs
// The input is zero-padded up to a power of two so odd counts reduce cleanly.
module eda_max_tree #(
   parameter int unsigned N           = 8,
   parameter int unsigned PIXEL_WIDTH = 8
) (
   input  logic [N*PIXEL_WIDTH-1:0] values,
   output logic [PIXEL_WIDTH-1:0]   max_value
);

   localparam int unsigned LEAVES = 1 << $clog2(N);

   logic [LEAVES*PIXEL_WIDTH-1:0] padded;
   logic [PIXEL_WIDTH-1:0]        node [0:2*LEAVES-2];

   // Heap-ordered tree: leaves at [LEAVES-1 ..], root at node[0].
   always_comb begin
      padded = (LEAVES*PIXEL_WIDTH)'(values);
      for (int unsigned i = 0; i < LEAVES; i++) begin
         node[LEAVES - 1 + i] = padded[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
      for (int i = int'(LEAVES) - 2; i >= 0; i--) begin
         node[i] = (node[2*i+1] >= node[2*i+2]) ? node[2*i+1] : node[2*i+2];
      end
      max_value = node[0];
   end

endmodule

// File: rtl/eda_compare_pipe.sv
// Regional-max window comparator with flood-fill index serialiser.
// Ports: clk, reset (async, active-high)
//        in_valid/in_ready + window_values, neigh_addr_valid : window input
//        iterated_idx : live mask of already-visited neighbours
//        res_valid/res_ready + compare_out, max_value, equal_mask : result
//        push_valid/push_ready + push_idx : equal, unvisited neighbour indices
//        busy : FSM not idle
module eda_compare_pipe
   import eda_compare_pkg::*;
#(
   parameter int unsigned PIXEL_WIDTH = 8,
   parameter int unsigned WIN_DIM     = 3,
   parameter int unsigned WINDOW_SIZE = WIN_DIM * WIN_DIM,
   parameter int unsigned NEIGH_NUM   = WINDOW_SIZE - 1,
   parameter int unsigned IDX_WIDTH   = $clog2(NEIGH_NUM)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [PIXEL_WIDTH*WINDOW_SIZE-1:0] window_values,
   input  logic [NEIGH_NUM-1:0]            neigh_addr_valid,
   input  logic [NEIGH_NUM-1:0]            iterated_idx,
   output logic                            res_valid,
   input  logic                            res_ready,
   output logic                            compare_out,
   output logic [PIXEL_WIDTH-1:0]          max_value,
   output logic [NEIGH_NUM-1:0]            equal_mask,
   output logic                            push_valid,
   input  logic                            push_ready,
   output logic [IDX_WIDTH-1:0]            push_idx,
   output logic                            busy
);

   localparam int unsigned CENTRE = centre_idx(WINDOW_SIZE);

   state_e                             state_q, state_d;
   logic [PIXEL_WIDTH*WINDOW_SIZE-1:0] win_q, win_d;
   logic [NEIGH_NUM-1:0]               addr_valid_q, addr_valid_d;
   logic [NEIGH_NUM-1:0]               pending_q, pending_d;

   logic                   in_ready_d, res_valid_d, compare_d, push_valid_d, busy_d;
   logic [PIXEL_WIDTH-1:0] max_d;
   logic [NEIGH_NUM-1:0]   equal_mask_d;
   logic [IDX_WIDTH-1:0]   push_idx_d;

   logic [PIXEL_WIDTH-1:0]           centre_c, tree_max_c;
   logic [NEIGH_NUM*PIXEL_WIDTH-1:0] neigh_masked_c;
   logic [NEIGH_NUM-1:0]             eq_c, pend_load_c, pend_next_c;

   // Split the captured window into centre and masked neighbours.
   always_comb begin
      centre_c       = win_q[CENTRE*PIXEL_WIDTH +: PIXEL_WIDTH];
      neigh_masked_c = '0;
      eq_c           = '0;
      for (int unsigned p = 0; p < WINDOW_SIZE; p++) begin
         if (p != CENTRE) begin
            if (addr_valid_q[neigh_idx(p, CENTRE)]) begin
               neigh_masked_c[neigh_idx(p, CENTRE)*PIXEL_WIDTH +: PIXEL_WIDTH] =
                  win_q[p*PIXEL_WIDTH +: PIXEL_WIDTH];
               eq_c[neigh_idx(p, CENTRE)] =
                  (win_q[p*PIXEL_WIDTH +: PIXEL_WIDTH] == centre_c);
            end
         end
      end
   end

   eda_max_tree #(
      .N           (NEIGH_NUM),
      .PIXEL_WIDTH (PIXEL_WIDTH)
   ) u_max_tree (
      .values    (neigh_masked_c),
      .max_value (tree_max_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      addr_valid_d = addr_valid_q;
      pending_d    = pending_q;
      res_valid_d  = res_valid;
      compare_d    = compare_out;
      max_d        = max_value;
      equal_mask_d = equal_mask;
      push_valid_d = 1'b0;
      push_idx_d   = push_idx;

      pend_load_c = equal_mask & ~iterated_idx;
      // Visited neighbours drop out every cycle; an accepted push drops its bit.
      pend_next_c = pending_q & ~iterated_idx;
      if (push_valid && push_ready) begin
         pend_next_c = pend_next_c & ~(NEIGH_NUM'(1) << push_idx);
      end

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               win_d        = window_values;
               addr_valid_d = neigh_addr_valid;
               state_d      = EVAL;
            end
         end
         EVAL: begin
            max_d        = tree_max_c;
            compare_d    = (centre_c >= tree_max_c);
            equal_mask_d = eq_c;
            res_valid_d  = 1'b1;
            state_d      = RESULT;
         end
         RESULT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               pending_d   = pend_load_c;
               if (pend_load_c == '0) begin
                  state_d = IDLE;
               end else begin
                  state_d      = EMIT;
                  push_valid_d = 1'b1;
                  push_idx_d   = IDX_WIDTH'(lowest_set(PRIO_W'(pend_load_c)));
               end
            end
         end
         EMIT: begin
            pending_d = pend_next_c;
            if (pend_next_c == '0) begin
               state_d = IDLE;
            end else begin
               push_valid_d = 1'b1;
               push_idx_d   = IDX_WIDTH'(lowest_set(PRIO_W'(pend_next_c)));
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         win_q        <= '0;
         addr_valid_q <= '0;
         pending_q    <= '0;
         in_ready     <= 1'b1;
         res_valid    <= 1'b0;
         compare_out  <= 1'b0;
         max_value    <= '0;
         equal_mask   <= '0;
         push_valid   <= 1'b0;
         push_idx     <= '0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_q        <= win_d;
         addr_valid_q <= addr_valid_d;
         pending_q    <= pending_d;
         in_ready     <= in_ready_d;
         res_valid    <= res_valid_d;
         compare_out  <= compare_d;
         max_value    <= max_d;
         equal_mask   <= equal_mask_d;
         push_valid   <= push_valid_d;
         push_idx     <= push_idx_d;
         busy         <= busy_d;
      end
   end

endmodule
